// File: rtl/fetch_stage_pkg.sv
// Shared constants and the F/D pipeline register payload for the fetch stage.
// The payload struct is reused by the later pipeline registers.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_VAL  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_VAL = 4096;
  localparam logic [31:0] NOP_IR       = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        valid;
    logic        addr_err;
  } fd_t;

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register with reset > flush > stall > load priority.
// Flush wins over stall, so a stalled slot can still be turned into a bubble.
module fd_reg
  import fetch_stage_pkg::*;
#(
  parameter fd_t RESET_VAL = '{pc: PC_RESET_VAL, ir: NOP_IR, valid: 1'b0, addr_err: 1'b0}
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic flush,
  input  fd_t  load_val,
  input  fd_t  flush_val,
  output fd_t  q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (flush) begin
      q <= flush_val;
    end else if (!stall) begin
      q <= load_val;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction-memory address/range check, and the
// F/D register. Bad fetch addresses are issued as NOPs carrying an error flag.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_VAL,
  parameter logic [31:0] IM_BASE  = IM_BASE_VAL,
  parameter int unsigned IM_WORDS = IM_WORDS_VAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] NPC,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] i_inst_addr,
  output logic [31:0] D_PC,
  output logic [31:0] D_IR,
  output logic        D_valid,
  output logic        D_addr_err
);

  localparam logic [31:0] IM_LAST = IM_BASE + IM_WORDS * 32'd4 - 32'd4;
  localparam fd_t FD_RESET = '{pc: PC_RESET, ir: NOP_IR, valid: 1'b0, addr_err: 1'b0};

  logic [31:0] pc_q;
  logic        err_f;
  fd_t         fd_load;
  fd_t         fd_bubble;
  fd_t         fd_q;

  // Flush redirects later stages only; the PC itself just honours stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else if (!stall) begin
      pc_q <= NPC;
    end
  end

  assign err_f = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);

  always_comb begin
    fd_load          = '0;
    fd_load.pc       = pc_q;
    fd_load.ir       = err_f ? NOP_IR : i_inst_rdata;
    fd_load.valid    = 1'b1;
    fd_load.addr_err = err_f;

    fd_bubble          = '0;
    fd_bubble.pc       = pc_q;
    fd_bubble.ir       = NOP_IR;
    fd_bubble.valid    = 1'b0;
    fd_bubble.addr_err = 1'b0;
  end

  fd_reg #(
    .RESET_VAL (FD_RESET)
  ) u_fd_reg (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .load_val  (fd_load),
    .flush_val (fd_bubble),
    .q         (fd_q)
  );

  assign F_PC        = pc_q;
  assign i_inst_addr = pc_q;
  assign D_PC        = fd_q.pc;
  assign D_IR        = fd_q.ir;
  assign D_valid     = fd_q.valid;
  assign D_addr_err  = fd_q.addr_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns its address as data and a
// simple next-PC model supplies PC+4 unless a redirect is requested.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] npc;
  logic [31:0] inst_rdata;
  logic [31:0] f_pc;
  logic [31:0] inst_addr;
  logic [31:0] d_pc;
  logic [31:0] d_ir;
  logic        d_valid;
  logic        d_addr_err;

  logic        redirect_en;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign inst_rdata = inst_addr;
  assign npc        = redirect_en ? redirect_pc : f_pc + 32'd4;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .NPC          (npc),
    .i_inst_rdata (inst_rdata),
    .F_PC         (f_pc),
    .i_inst_addr  (inst_addr),
    .D_PC         (d_pc),
    .D_IR         (d_ir),
    .D_valid      (d_valid),
    .D_addr_err   (d_addr_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Sets the inputs, then advances one rising edge and settles 1 time unit past it.
  task automatic applyStimulus(input logic s, input logic f, input logic r_en, input logic [31:0] r_pc);
    stall       = s;
    flush       = f;
    redirect_en = r_en;
    redirect_pc = r_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic redirectAndLoad(input logic [31:0] target);
    applyStimulus(1'b0, 1'b0, 1'b1, target);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;

    #2;
    checkOutput("rst_fpc",   f_pc,               32'h3000);
    checkOutput("rst_iaddr", inst_addr,          32'h3000);
    checkOutput("rst_dpc",   d_pc,               32'h3000);
    checkOutput("rst_dir",   d_ir,               32'h0);
    checkOutput("rst_valid", {31'b0, d_valid},   32'h0);
    checkOutput("rst_err",   {31'b0, d_addr_err}, 32'h0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("run_fpc",   f_pc,             32'h300C);
    checkOutput("run_dpc",   d_pc,             32'h3008);
    checkOutput("run_dir",   d_ir,             32'h3008);
    checkOutput("run_valid", {31'b0, d_valid}, 32'h1);

    #3;
    reset = 1'b1;
    #1;
    checkOutput("midrst_fpc",   f_pc,             32'h3000);
    checkOutput("midrst_valid", {31'b0, d_valid}, 32'h0);
    checkOutput("midrst_dir",   d_ir,             32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("postrst_dir", d_ir, 32'h3000);
    checkOutput("postrst_fpc", f_pc, 32'h3004);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("prestall_fpc", f_pc, 32'h3010);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_fpc", f_pc, 32'h3010);
      checkOutput("stall_dpc", d_pc, 32'h300C);
      checkOutput("stall_dir", d_ir, 32'h300C);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("unstall_fpc", f_pc, 32'h3014);
    checkOutput("unstall_dpc", d_pc, 32'h3010);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("preflush_fpc", f_pc, 32'h3020);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("flstall_fpc",   f_pc,             32'h3020);
    checkOutput("flstall_dir",   d_ir,             32'h0);
    checkOutput("flstall_valid", {31'b0, d_valid}, 32'h0);
    checkOutput("flstall_dpc",   d_pc,             32'h3020);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("refetch_dir",   d_ir,             32'h3020);
    checkOutput("refetch_valid", {31'b0, d_valid}, 32'h1);
    checkOutput("refetch_fpc",   f_pc,             32'h3024);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("flush_fpc",   f_pc,             32'h3028);
    checkOutput("flush_valid", {31'b0, d_valid}, 32'h0);
    checkOutput("flush_dpc",   d_pc,             32'h3024);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000);
    checkOutput("redir_fpc", f_pc, 32'h4000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_dpc",   d_pc,             32'h4000);
    checkOutput("redir_dir",   d_ir,             32'h4000);
    checkOutput("redir_valid", {31'b0, d_valid}, 32'h1);

    redirectAndLoad(32'h3002);
    checkOutput("mis_err",   {31'b0, d_addr_err}, 32'h1);
    checkOutput("mis_dir",   d_ir,                32'h0);
    checkOutput("mis_valid", {31'b0, d_valid},    32'h1);
    checkOutput("mis_dpc",   d_pc,                32'h3002);

    redirectAndLoad(32'h7000);
    checkOutput("hi_err", {31'b0, d_addr_err}, 32'h1);
    checkOutput("hi_dir", d_ir,                32'h0);

    redirectAndLoad(32'h6FFC);
    checkOutput("last_err", {31'b0, d_addr_err}, 32'h0);
    checkOutput("last_dir", d_ir,                32'h6FFC);

    redirectAndLoad(32'h2FFC);
    checkOutput("lo_err", {31'b0, d_addr_err}, 32'h1);

    redirectAndLoad(32'h3000);
    checkOutput("base_err", {31'b0, d_addr_err}, 32'h0);
    checkOutput("base_dir", d_ir,                32'h3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
